// File: rtl/operand_conditioner.sv
// operand_conditioner: registered operand conditioner placed in front of the ALU adder.
// Supported modes are pass, one's complement, two's-complement negate and force-zero.
// Alongside the data it emits a carry-in hint (CIN) and a negate-overflow flag (OVF).
// A valid/ready handshake feeds a 2-entry skid buffer, so back-pressure never drops or
// duplicates an operand.
// Optional feature: define OPERAND_CONDITIONER_SAT_EN to saturate the negate of the
// most-negative value to the maximum positive value. Without it the negate wraps.
module operand_conditioner #(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] Dato,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             CIN,
    output logic             OVF
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             cin;
        logic             ovf;
    } entry_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef OPERAND_CONDITIONER_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t condEntry;

    logic inXfer;
    logic outXfer;
    logic outValid;
    logic inReady;

    // Conditioning function applied to the incoming operand; the result is stored with the entry
    always_comb begin
        condEntry     = '0;
        condEntry.y   = '0;
        condEntry.cin = 1'b0;
        condEntry.ovf = 1'b0;
        case (MODE)
            2'b00: begin
                condEntry.y = Dato;
            end
            2'b01: begin
                condEntry.y   = ~Dato;
                condEntry.cin = 1'b1;
            end
            2'b10: begin
                condEntry.y   = ~Dato + ONE_LSB;
                condEntry.ovf = (Dato == MOST_NEG);
`ifdef OPERAND_CONDITIONER_SAT_EN
                if (Dato == MOST_NEG) begin
                    condEntry.y = MAX_POS;
                end
`endif
            end
            default: begin
                condEntry.y   = '0;
                condEntry.cin = 1'b0;
                condEntry.ovf = 1'b0;
            end
        endcase
    end

    assign inXfer  = IN_VALID & inReady;
    assign outXfer = outValid & OUT_READY;

    // State register: the buffer occupancy; reset discards every buffered entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: move between empty, one-entry and full occupancy on transfers
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (inXfer) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (inXfer && !outXfer) begin
                    state_d = FULL;
                end else if (!inXfer && outXfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (outXfer) begin
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Output decode: handshake flags depend on the registered state only
    always_comb begin
        outValid = 1'b0;
        inReady  = 1'b1;
        case (state_q)
            EMPTY: begin
                outValid = 1'b0;
                inReady  = 1'b1;
            end
            ONE: begin
                outValid = 1'b1;
                inReady  = 1'b1;
            end
            FULL: begin
                outValid = 1'b1;
                inReady  = 1'b0;
            end
            default: begin
                outValid = 1'b0;
                inReady  = 1'b1;
            end
        endcase
    end

    // Entry steering: new operand to main or skid, skid promoted to main when main drains
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: begin
                if (inXfer) begin
                    main_d = condEntry;
                end
            end
            ONE: begin
                if (inXfer && outXfer) begin
                    main_d = condEntry;
                end else if (inXfer) begin
                    skid_d = condEntry;
                end
            end
            FULL: begin
                if (outXfer) begin
                    main_d = skid_q;
                end
            end
            default: begin
                main_d = main_q;
                skid_d = skid_q;
            end
        endcase
    end

    // Entry registers: main drives the outputs, skid holds the one extra operand
    always_ff @(posedge CLK) begin
        if (RST) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign OUT_VALID = outValid;
    assign IN_READY  = inReady;
    assign Y         = main_q.y;
    assign CIN       = main_q.cin;
    assign OVF       = main_q.ovf;

endmodule
